uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin transmit arbiter that shares the single UART transmit FIFO (`write_to_uart` / `tx_data` / `tx_full`) among `NUM_REQ` byte-stream requesters. A grant is held for a whole message, delimited by `req_last`, so bytes from different requesters never interleave on `tx`. A watchdog reclaims the channel from a requester that stalls mid-message. The block sits between on-chip producers and the UART module, driving its transmit-side inputs directly.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `TRANSMITTED_BITS`, 8: byte width, matching the UART module.
- `MAX_STALL`, 16'd1000: number of consecutive granted cycles with `req_valid` low, and not blocked by `tx_full`, before the grant is aborted.
- `clock` input 1: system clock.
- `reset` input 1: asynchronous, active-high.
- `req_valid` input NUM_REQ: requester i has a byte on its data lane.
- `req_data` input NUM_REQ*TRANSMITTED_BITS: lane i occupies bits [i*TRANSMITTED_BITS +: TRANSMITTED_BITS].
- `req_last` input NUM_REQ: the byte on lane i is the final byte of its message.
- `req_ready` output NUM_REQ: byte on lane i is accepted this cycle when valid and ready are both high.
- `tx_full` input 1: UART transmit FIFO full.
- `tx_data` output TRANSMITTED_BITS: byte to the UART.
- `write_to_uart` output 1: single-cycle FIFO write strobe.
- `grant_id` output clog2(NUM_REQ): current owner, valid while `busy` is high.
- `busy` output 1: a grant is held.
- `abort` output 1: one-cycle pulse when the watchdog revokes a grant.

## Operation
- FSM states:
  - IDLE: no grant.
  - GRANT: owner = `grant_id`.
- IDLE → GRANT:
  - Taken when any `req_valid` bit is high.
  - Winner is the first set bit searching upward from `last_grant+1`, wrapping modulo NUM_REQ.
  - `grant_id` is registered on this transition.
- In GRANT:
  - `req_ready[grant_id] = !tx_full`; every other `req_ready` bit is 0.
  - `write_to_uart = req_valid[grant_id] & !tx_full` (combinational).
  - `tx_data = req_data` lane `grant_id` (combinational mux). When no write occurs, `tx_data` holds the granted lane.
- GRANT → IDLE when either of these happens:
  - A byte is accepted with `req_last[grant_id]=1`. `last_grant` ← `grant_id`.
  - The stall counter reaches MAX_STALL. `abort` pulses, `last_grant` ← `grant_id`, and the partial message is dropped; no pad byte is sent.
- Stall counter:
  - Cleared on entering GRANT and on every accepted byte.
  - Increments on cycles where `req_valid[grant_id]=0`.
  - Holds on cycles where `tx_full=1`.
- Requests on other lanes during GRANT are ignored until return to IDLE. No preemption.
- A requester that deasserts valid mid-message keeps the grant until MAX_STALL expires.
- A single-byte message (`last` on the first byte) is legal.

## Timing
- Reset values:
  - State IDLE, `busy`=0, `grant_id`=0, `abort`=0.
  - `last_grant`=NUM_REQ-1, so lane 0 wins first.
  - Stall counter=0.
  - `req_ready`=0 and `write_to_uart`=0, since both depend on state.
- Request-to-first-write latency from IDLE: 1 cycle. The `req_valid` rise is seen at edge N; GRANT holds from N+1, and the write can occur in that same cycle.
- Throughput: one byte per cycle while `tx_full`=0.
- `tx_full` is honoured combinationally. The UART sees no write in any cycle where `tx_full`=1.
- After `last`, one IDLE cycle always separates grants. Minimum spacing between the end of one message and the first byte of the next is 2 cycles.
- Last byte and stall expiry in the same cycle: the accepted last byte wins and `abort` is not pulsed. The counter cannot expire on an accept cycle anyway, because an accept clears it.
- Asynchronous reset mid-message forces IDLE immediately. Any byte presented in that cycle is not written.

## Structure
- Package `uart_arb_pkg`:
  - State enum (IDLE, GRANT).
  - `ID_W` helper function (clog2).
  - Default MAX_STALL constant.
- Sub-module `rr_priority_picker`: combinational round-robin search. Inputs are the request vector and `last_grant`; outputs are `winner_id` and `any_req`.
- Top level holds the FSM, the grant register, the stall counter and the lane mux.
- Target size: about 150–250 lines of RTL.

## Test plan
- Reset, then lane 2 sends 0x41, 0x42, 0x43 (last on 0x43) with `tx_full`=0:
  - Three consecutive `write_to_uart` pulses carrying 0x41/0x42/0x43.
  - `busy` falls 1 cycle after 0x43.
- Lanes 0, 1 and 3 request simultaneously from reset, each with a 2-byte message. Required grant order is 0, 1, 3, then 0 again after lane 0 re-requests.
- Lane 1 is mid-message and `tx_full` is held high for 50 cycles:
  - No writes and `req_ready[1]`=0 throughout.
  - No abort.
  - Transmission resumes on the first cycle `tx_full`=0.
- Lane 0 sends 0x10, then drops valid with MAX_STALL=8:
  - `abort` pulses exactly 8 cycles later.
  - `busy`=0 on the next cycle.
  - A pending lane 1 is granted.
- Reset is asserted during byte 2 of a 4-byte message on lane 3:
  - Outputs clear asynchronously and no further writes occur.
  - After release, lane 0 has priority.
- Lane 2 sends a single-byte message (0x7E with last) while lane 2 also requests again: lane 2 is regranted only after the other pending lanes have been served.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
// Imported by the arbiter top and its round-robin picker.
package uart_arb_pkg;

  typedef enum logic {
    IDLE,
    GRANT
  } arb_state_t;

  localparam logic [15:0] DEF_MAX_STALL = 16'd1000;

  function automatic int id_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin search: first request above
// last_grant, wrapping modulo NUM_REQ.
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      last_grant,
  output logic [IW-1:0]      winner_id,
  output logic               any_req
);

  // Unrolled per last_grant value so every lane index is a constant.
  always_comb begin
    winner_id = '0;
    for (int lg = 0; lg < NUM_REQ; lg++) begin
      if (last_grant == lg[IW-1:0]) begin
        for (int k = NUM_REQ; k >= 1; k--) begin
          if (req[(lg + k) % NUM_REQ])
            winner_id = IW'((lg + k) % NUM_REQ);
        end
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter in front of the UART
// transmit FIFO, with a stall watchdog on the current owner.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int          NUM_REQ          = 4,
  parameter int          TRANSMITTED_BITS = 8,
  parameter logic [15:0] MAX_STALL        = DEF_MAX_STALL,
  localparam int         IW               = id_w(NUM_REQ)
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ*TRANSMITTED_BITS-1:0] req_data,
  input  logic [NUM_REQ-1:0]                  req_last,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic                                tx_full,
  output logic [TRANSMITTED_BITS-1:0]         tx_data,
  output logic                                write_to_uart,
  output logic [IW-1:0]                       grant_id,
  output logic                                busy,
  output logic                                abort
);

  arb_state_t  state;
  logic [IW-1:0] last_grant;
  logic [15:0] stall_cnt;

  logic [IW-1:0] winner_id;
  logic          any_req;
  logic          sel_valid;
  logic          sel_last;
  logic          granted;
  logic          accept;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_picker (
    .req        (req_valid),
    .last_grant (last_grant),
    .winner_id  (winner_id),
    .any_req    (any_req)
  );

  assign granted   = (state == GRANT);
  assign sel_valid = req_valid[grant_id];
  assign sel_last  = req_last[grant_id];
  assign accept    = granted && sel_valid && !tx_full;

  assign busy          = granted;
  assign write_to_uart = accept;
  // An accept on the expiry cycle takes priority over the abort.
  assign abort = granted && (stall_cnt >= MAX_STALL) && !accept;

  always_comb begin
    req_ready = '0;
    if (granted)
      req_ready[grant_id] = !tx_full;
  end

  always_comb begin
    tx_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == i[IW-1:0])
        tx_data = req_data[i*TRANSMITTED_BITS +: TRANSMITTED_BITS];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      stall_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            state     <= GRANT;
            grant_id  <= winner_id;
            stall_cnt <= '0;
          end
        end
        GRANT: begin
          if (accept) begin
            stall_cnt <= '0;
            if (sel_last) begin
              state      <= IDLE;
              last_grant <= grant_id;
            end
          end else if (abort) begin
            state      <= IDLE;
            last_grant <= grant_id;
            stall_cnt  <= '0;
          end else if (!sel_valid && !tx_full) begin
            stall_cnt <= stall_cnt + 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed, table-driven bench for uart_tx_arbiter
// (NUM_REQ=4, 8-bit lanes, MAX_STALL=8).
module tb_uart_tx_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_full;
  logic [7:0]  tx_data;
  logic        write_to_uart;
  logic [1:0]  grant_id;
  logic        busy;
  logic        abort;

  int n_chk  = 0;
  int n_fail = 0;

  uart_tx_arbiter #(
    .NUM_REQ          (4),
    .TRANSMITTED_BITS (8),
    .MAX_STALL        (16'd8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .tx_full       (tx_full),
    .tx_data       (tx_data),
    .write_to_uart (write_to_uart),
    .grant_id      (grant_id),
    .busy          (busy),
    .abort         (abort)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic [3:0]  valid;
    logic [3:0]  last;
    logic [31:0] data;
    logic        full;
    logic        wr;
    logic [7:0]  txd;
    logic        bsy;
    logic [3:0]  rdy;
    logic [1:0]  gid;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    logic rst, logic [3:0] valid, logic [3:0] last,
    logic [31:0] data, logic wr, logic [7:0] txd,
    logic bsy, logic [3:0] rdy, logic [1:0] gid);
    vec_t v;
    v.rst = rst; v.valid = valid; v.last = last;
    v.data = data; v.full = 1'b0; v.wr = wr;
    v.txd = txd; v.bsy = bsy; v.rdy = rdy; v.gid = gid;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(logic [3:0] v, logic [3:0] l,
                       logic [31:0] d, logic f);
    req_valid = v;
    req_last  = l;
    req_data  = d;
    tx_full   = f;
  endtask

  task automatic exp_out(string nm, logic wr, logic [7:0] txd,
                         logic bsy, logic [3:0] rdy,
                         logic [1:0] gid, logic ab);
    #1;
    chk({nm, "_wr"}, 32'(write_to_uart), 32'(wr));
    if (wr) chk({nm, "_txd"}, 32'(tx_data), 32'(txd));
    chk({nm, "_busy"}, 32'(busy), 32'(bsy));
    chk({nm, "_rdy"}, 32'(req_ready), 32'(rdy));
    if (bsy) chk({nm, "_gid"}, 32'(grant_id), 32'(gid));
    chk({nm, "_abort"}, 32'(abort), 32'(ab));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(4'b1111, 4'b0000, 32'h0, 1'b0);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_gid", 32'(grant_id), 0);
    chk("rst_abort", 32'(abort), 0);
    chk("rst_wr", 32'(write_to_uart), 0);
    chk("rst_rdy", 32'(req_ready), 0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    drive(4'b0000, 4'b0000, 32'h0, 1'b0);

    // lane 2 three-byte message
    vq.push_back(mk(1, 4'b0100, 4'b0000, 32'h0041_0000, 0, 8'h00, 0, 4'b0000, 2'd0));
    vq.push_back(mk(0, 4'b0100, 4'b0000, 32'h0041_0000, 1, 8'h41, 1, 4'b0100, 2'd2));
    vq.push_back(mk(0, 4'b0100, 4'b0000, 32'h0042_0000, 1, 8'h42, 1, 4'b0100, 2'd2));
    vq.push_back(mk(0, 4'b0100, 4'b0100, 32'h0043_0000, 1, 8'h43, 1, 4'b0100, 2'd2));
    vq.push_back(mk(0, 4'b0000, 4'b0000, 32'h0000_0000, 0, 8'h00, 0, 4'b0000, 2'd0));
    // lanes 0,1,3 contend from reset; lane 0 re-requests
    vq.push_back(mk(1, 4'b1011, 4'b0000, 32'hD000_B0A0, 0, 8'h00, 0, 4'b0000, 2'd0));
    vq.push_back(mk(0, 4'b1011, 4'b0000, 32'hD000_B0A0, 1, 8'hA0, 1, 4'b0001, 2'd0));
    vq.push_back(mk(0, 4'b1011, 4'b0001, 32'hD000_B0A1, 1, 8'hA1, 1, 4'b0001, 2'd0));
    vq.push_back(mk(0, 4'b1010, 4'b0000, 32'hD000_B000, 0, 8'h00, 0, 4'b0000, 2'd0));
    vq.push_back(mk(0, 4'b1010, 4'b0000, 32'hD000_B000, 1, 8'hB0, 1, 4'b0010, 2'd1));
    vq.push_back(mk(0, 4'b1010, 4'b0010, 32'hD000_B100, 1, 8'hB1, 1, 4'b0010, 2'd1));
    vq.push_back(mk(0, 4'b1001, 4'b0000, 32'hD000_00A2, 0, 8'h00, 0, 4'b0000, 2'd0));
    vq.push_back(mk(0, 4'b1001, 4'b0000, 32'hD000_00A2, 1, 8'hD0, 1, 4'b1000, 2'd3));
    vq.push_back(mk(0, 4'b1001, 4'b1000, 32'hD100_00A2, 1, 8'hD1, 1, 4'b1000, 2'd3));
    vq.push_back(mk(0, 4'b0001, 4'b0001, 32'h0000_00A2, 0, 8'h00, 0, 4'b0000, 2'd0));
    vq.push_back(mk(0, 4'b0001, 4'b0001, 32'h0000_00A2, 1, 8'hA2, 1, 4'b0001, 2'd0));
    vq.push_back(mk(0, 4'b0000, 4'b0000, 32'h0000_0000, 0, 8'h00, 0, 4'b0000, 2'd0));

    foreach (vq[i]) begin
      if (vq[i].rst) do_reset();
      drive(vq[i].valid, vq[i].last, vq[i].data, vq[i].full);
      exp_out($sformatf("vec%0d", i), vq[i].wr, vq[i].txd,
              vq[i].bsy, vq[i].rdy, vq[i].gid, 1'b0);
      tick();
    end

    // lane 1 held off by tx_full for 50 cycles
    drive(4'b0010, 4'b0000, 32'h0000_5100, 1'b0);
    exp_out("full_idle", 0, 8'h00, 0, 4'b0000, 2'd0, 0);
    tick();
    exp_out("full_b0", 1, 8'h51, 1, 4'b0010, 2'd1, 0);
    tick();
    for (int k = 0; k < 50; k++) begin
      drive((k < 25) ? 4'b0010 : 4'b0000, 4'b0000, 32'h0000_5200, 1'b1);
      exp_out($sformatf("full_hold%0d", k), 0, 8'h00, 1, 4'b0000, 2'd1, 0);
      tick();
    end
    drive(4'b0010, 4'b0010, 32'h0000_5200, 1'b0);
    exp_out("full_resume", 1, 8'h52, 1, 4'b0010, 2'd1, 0);
    tick();
    drive(4'b0000, 4'b0000, 32'h0, 1'b0);
    exp_out("full_end", 0, 8'h00, 0, 4'b0000, 2'd0, 0);
    tick();

    // lane 0 stalls mid-message, lane 1 pending
    drive(4'b0011, 4'b0010, 32'h0000_6110, 1'b0);
    exp_out("stall_idle", 0, 8'h00, 0, 4'b0000, 2'd0, 0);
    tick();
    exp_out("stall_b0", 1, 8'h10, 1, 4'b0001, 2'd0, 0);
    tick();
    for (int k = 0; k < 8; k++) begin
      drive(4'b0010, 4'b0010, 32'h0000_6100, 1'b0);
      exp_out($sformatf("stall_wait%0d", k), 0, 8'h00, 1, 4'b0001, 2'd0, 0);
      tick();
    end
    exp_out("stall_abort", 0, 8'h00, 1, 4'b0001, 2'd0, 1);
    tick();
    exp_out("stall_after", 0, 8'h00, 0, 4'b0000, 2'd0, 0);
    tick();
    exp_out("stall_next", 1, 8'h61, 1, 4'b0010, 2'd1, 0);
    tick();
    drive(4'b0000, 4'b0000, 32'h0, 1'b0);
    exp_out("stall_end", 0, 8'h00, 0, 4'b0000, 2'd0, 0);
    tick();

    // reset during byte 2 of a lane 3 message
    drive(4'b1000, 4'b0000, 32'h3100_0000, 1'b0);
    exp_out("rst3_idle", 0, 8'h00, 0, 4'b0000, 2'd0, 0);
    tick();
    exp_out("rst3_b0", 1, 8'h31, 1, 4'b1000, 2'd3, 0);
    tick();
    drive(4'b1000, 4'b0000, 32'h3200_0000, 1'b0);
    reset = 1'b1;
    exp_out("rst3_async", 0, 8'h00, 0, 4'b0000, 2'd0, 0);
    chk("rst3_gid", 32'(grant_id), 0);
    tick();
    exp_out("rst3_held", 0, 8'h00, 0, 4'b0000, 2'd0, 0);
    reset = 1'b0;
    drive(4'b1001, 4'b0001, 32'h3200_0070, 1'b0);
    exp_out("rst3_rel", 0, 8'h00, 0, 4'b0000, 2'd0, 0);
    tick();
    exp_out("rst3_lane0", 1, 8'h70, 1, 4'b0001, 2'd0, 0);
    tick();
    drive(4'b0000, 4'b0000, 32'h0, 1'b0);
    exp_out("rst3_end", 0, 8'h00, 0, 4'b0000, 2'd0, 0);
    tick();

    // lane 2 single-byte message then re-request
    drive(4'b1101, 4'b1101, 32'h3A7E_000A, 1'b0);
    exp_out("rr_idle0", 0, 8'h00, 0, 4'b0000, 2'd0, 0);
    tick();
    exp_out("rr_lane2", 1, 8'h7E, 1, 4'b0100, 2'd2, 0);
    tick();
    drive(4'b1101, 4'b1101, 32'h3A7F_000A, 1'b0);
    exp_out("rr_idle1", 0, 8'h00, 0, 4'b0000, 2'd0, 0);
    tick();
    exp_out("rr_lane3", 1, 8'h3A, 1, 4'b1000, 2'd3, 0);
    tick();
    drive(4'b0101, 4'b0101, 32'h007F_000A, 1'b0);
    exp_out("rr_idle2", 0, 8'h00, 0, 4'b0000, 2'd0, 0);
    tick();
    exp_out("rr_lane0", 1, 8'h0A, 1, 4'b0001, 2'd0, 0);
    tick();
    drive(4'b0100, 4'b0100, 32'h007F_0000, 1'b0);
    exp_out("rr_idle3", 0, 8'h00, 0, 4'b0000, 2'd0, 0);
    tick();
    exp_out("rr_lane2b", 1, 8'h7F, 1, 4'b0100, 2'd2, 0);
    tick();
    drive(4'b0000, 4'b0000, 32'h0, 1'b0);
    exp_out("rr_end", 0, 8'h00, 0, 4'b0000, 2'd0, 0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
